// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg
// Shared definitions for the FIFO burst reader: the controller state
// encoding and the default data / length widths used by the top level,
// the stream interface and the holding buffer.
package fifo_rd_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// fifo_burst_reader_if
// Valid/ready byte stream produced by the burst reader.
//   data  : stream payload
//   valid : payload present
//   last  : payload is the final byte of the burst
//   ready : downstream accepts the payload this cycle
// master modport is the producer (the reader), slave is the consumer.
interface fifo_burst_reader_if
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    logic [DATA_W-1:0] data;
    logic              valid;
    logic              last;
    logic              ready;

    modport master (
        output data,
        output valid,
        output last,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  last,
        output ready
    );

endinterface

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid
// Two-entry in-order holding buffer that absorbs the FIFO read latency.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : write wr_data at the tail this cycle
//   wr_data    : byte returned by the FIFO
//   pop        : head entry consumed this cycle (only while occ != 0)
//   head       : oldest buffered byte
//   occ        : number of buffered entries (0..2)
// The writer guarantees there is never a write into a full buffer
// without a simultaneous pop.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        occ
);

    logic [DATA_W-1:0] ent0;
    logic [DATA_W-1:0] ent1;
    logic [1:0]        occ_q;
    logic              widx;

    // Tail slot after this cycle's pop has shifted the entries down.
    assign widx = (occ_q == 2'd2) || ((occ_q == 2'd1) && !pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0  <= '0;
            ent1  <= '0;
            occ_q <= 2'd0;
        end else begin
            if (pop) begin
                ent0 <= ent1;
            end
            // A write into slot 0 during a pop must override the shift above.
            if (wr_en) begin
                if (widx) begin
                    ent1 <= wr_data;
                end else begin
                    ent0 <= wr_data;
                end
            end
            occ_q <= occ_q + {1'b0, wr_en} - {1'b0, pop};
        end
    end

    assign head = ent0;
    assign occ  = occ_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
// Read-side burst engine for the byte FIFO. A start command pops exactly
// len bytes, buffers the FIFO's one-cycle read latency in fifo_rd_skid and
// presents the bytes as a valid/ready stream with a last marker.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start, len  : burst request and length, sampled only in IDLE
//   busy        : burst in progress
//   done        : one-cycle pulse at burst end
//   fifo_rd_en  : pop request to the FIFO
//   fifo_dout   : FIFO read data, valid the cycle after a pop
//   fifo_empty  : FIFO empty flag
//   m           : output stream (data / valid / last / ready)
//   rd_count    : bytes handshaken in the current burst
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [LEN_W-1:0]           len,
    output logic                       busy,
    output logic                       done,
    output logic                       fifo_rd_en,
    input  logic [DATA_W-1:0]          fifo_dout,
    input  logic                       fifo_empty,
    fifo_burst_reader_if.master        m,
    output logic [LEN_W-1:0]           rd_count
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued;
    logic              inflight;
    logic [1:0]        occ;
    logic [DATA_W-1:0] head;
    logic              pop;
    logic [2:0]        slots;

    assign pop = m.valid && m.ready;

    // Buffer entries still claimed after this cycle: what is held plus the
    // byte on its way back from the FIFO, minus the one leaving downstream.
    // occ == 0 forces pop == 0, so this never underflows.
    assign slots = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (pop && m.last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        fifo_rd_en = 1'b0;
        unique case (state)
            READ: begin
                busy       = 1'b1;
                fifo_rd_en = !fifo_empty && (issued < len_q) && (slots < 3'd2);
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            issued   <= '0;
            rd_count <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            if ((state == IDLE) && start) begin
                len_q    <= len;
                issued   <= '0;
                rd_count <= '0;
            end else begin
                if (fifo_rd_en) begin
                    issued <= issued + LEN_ONE;
                end
                if (pop) begin
                    rd_count <= rd_count + LEN_ONE;
                end
            end
        end
    end

    // The byte requested last cycle is on fifo_dout now.
    fifo_rd_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (inflight),
        .wr_data (fifo_dout),
        .pop     (pop),
        .head    (head),
        .occ     (occ)
    );

    assign m.valid = (occ != 2'd0);
    assign m.data  = head;
    assign m.last  = m.valid && (rd_count == (len_q - LEN_ONE));

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader
// Drives the burst reader from a behavioural byte FIFO. Every byte pushed
// into the FIFO model is also queued as the expected stream; the stream
// monitor pops and compares on each handshake.
module tb_fifo_burst_reader;
    import fifo_rd_pkg::*;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_empty;
    logic [LEN_W-1:0]  rd_count;

    fifo_burst_reader_if #(.DATA_W(DATA_W)) s_if ();

    fifo_burst_reader #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .m          (s_if),
        .rd_count   (rd_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int mon_len    = 0;
    int mon_beats  = 0;
    int cyc        = 0;
    int first_cyc  = 0;
    int last_cyc   = 0;
    int pops       = 0;
    bit rd_seen    = 0;
    bit vld_seen   = 0;

    // Byte FIFO model: registered read data, empty flag updated at the edge.
    always @(posedge clk) begin
        cyc++;
        if (fifo_rd_en) begin
            if (fifo_q.size() > 0) begin
                fifo_dout <= fifo_q.pop_front();
                pops++;
            end else begin
                errors++;
                $display("FAIL fifo_underrun: pop with FIFO empty at cycle %0d", cyc);
            end
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Stream monitor / scoreboard.
    always @(negedge clk) begin
        logic [7:0] exp_b;
        bit         exp_last;
        if (fifo_rd_en) rd_seen = 1'b1;
        if (s_if.valid) vld_seen = 1'b1;
        if (rst_n && fifo_rd_en && fifo_empty) begin
            errors++;
            $display("FAIL rd_en_while_empty: fifo_rd_en=1 required 0 at cycle %0d", cyc);
        end
        if (rst_n && s_if.valid && s_if.ready) begin
            if (mon_beats == 0) first_cyc = cyc;
            last_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL stream_data: got beat 0x%02h, required no beat", s_if.data);
            end else begin
                exp_b = exp_q.pop_front();
                if (s_if.data !== exp_b) begin
                    errors++;
                    $display("FAIL stream_data: got 0x%02h required 0x%02h (beat %0d)",
                             s_if.data, exp_b, mon_beats);
                end
            end
            exp_last = (mon_beats == mon_len - 1);
            checks++;
            if (s_if.last !== exp_last) begin
                errors++;
                $display("FAIL stream_last: got %b required %b (beat %0d)",
                         s_if.last, exp_last, mon_beats);
            end
            mon_beats++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        fifo_q.push_back(v);
        exp_q.push_back(v);
        fifo_empty = 1'b0;
    endtask

    task automatic flush();
        fifo_q.delete();
        exp_q.delete();
        fifo_empty = 1'b1;
        mon_beats  = 0;
        rd_seen    = 1'b0;
        vld_seen   = 1'b0;
        pops       = 0;
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        len   = n[LEN_W-1:0];
        tick();
        start = 1'b0;
        len   = 8'hEE;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        len   = '0;
        s_if.ready = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout  = 8'h00;
        repeat (3) tick();
        checks++;
        if ({busy, done, fifo_rd_en, s_if.valid, s_if.last} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy/done/rd_en/valid/last=%b required 00000",
                     {busy, done, fifo_rd_en, s_if.valid, s_if.last});
        end
        checks++;
        if (s_if.data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got 0x%02h required 0x00", s_if.data);
        end
        checks++;
        if (rd_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_rd_count: got %0d required 0", rd_count);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        bit ok;
        flush();
        push(8'd10); push(8'd20); push(8'd30);
        mon_len = 3;
        s_if.ready = 1'b1;
        tick();
        do_start(3);
        wait_done(20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_done: got no done required done within 20 cycles"); end
        checks++;
        if (rd_count !== 8'd3) begin errors++; $display("FAIL basic_rd_count: got %0d required 3", rd_count); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b required 0", busy); end
        checks++;
        if (mon_beats != 3) begin errors++; $display("FAIL basic_beats: got %0d required 3", mon_beats); end
        checks++;
        if (last_cyc - first_cyc != 2) begin
            errors++;
            $display("FAIL basic_throughput: beats spanned %0d cycles required 2", last_cyc - first_cyc);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b required 0", done); end
    endtask

    task automatic test_zero_len();
        bit ok;
        flush();
        push(8'h77);
        exp_q.delete();
        mon_len = 0;
        tick();
        rd_seen  = 1'b0;
        vld_seen = 1'b0;
        do_start(0);
        wait_done(3, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL zero_done: got no done required done within 3 cycles"); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b required 0", busy); end
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse: got %b required 0", done); end
        checks++;
        if (rd_seen) begin errors++; $display("FAIL zero_rd_en: got rd_en high required never"); end
        checks++;
        if (vld_seen) begin errors++; $display("FAIL zero_valid: got valid high required never"); end
        checks++;
        if (fifo_q.size() != 1) begin errors++; $display("FAIL zero_fifo_left: got %0d required 1", fifo_q.size()); end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit unstable;
        flush();
        for (int i = 0; i < 5; i++) push(8'h51 + 8'(i));
        mon_len = 5;
        s_if.ready = 1'b0;
        tick();
        pops = 0;
        do_start(5);
        unstable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (s_if.valid && s_if.data !== 8'h51) unstable = 1'b1;
        end
        checks++;
        if (pops != 2) begin errors++; $display("FAIL bp_pops: got %0d required 2", pops); end
        checks++;
        if (s_if.valid !== 1'b1 || s_if.data !== 8'h51) begin
            errors++;
            $display("FAIL bp_hold: valid=%b data=0x%02h required valid=1 data=0x51", s_if.valid, s_if.data);
        end
        checks++;
        if (unstable) begin errors++; $display("FAIL bp_stable: data changed while stalled required held 0x51"); end
        s_if.ready = 1'b1;
        wait_done(20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_done: got no done required done within 20 cycles"); end
        checks++;
        if (mon_beats != 5) begin errors++; $display("FAIL bp_beats: got %0d required 5", mon_beats); end
        checks++;
        if (pops != 5) begin errors++; $display("FAIL bp_total_pops: got %0d required 5", pops); end
        tick();
    endtask

    task automatic test_underflow();
        bit ok;
        flush();
        push(8'd1);
        mon_len = 4;
        s_if.ready = 1'b1;
        tick();
        do_start(4);
        repeat (5) tick();
        checks++;
        if (mon_beats != 1 || busy !== 1'b1 || s_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL uf_stall1: beats=%0d busy=%b valid=%b required 1/1/0", mon_beats, busy, s_if.valid);
        end
        push(8'd2);
        tick();
        push(8'd2);
        repeat (5) tick();
        checks++;
        if (mon_beats != 3 || busy !== 1'b1 || s_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL uf_stall2: beats=%0d busy=%b valid=%b required 3/1/0", mon_beats, busy, s_if.valid);
        end
        push(8'd4);
        wait_done(20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL uf_done: got no done required done within 20 cycles"); end
        checks++;
        if (mon_beats != 4 || rd_count !== 8'd4) begin
            errors++;
            $display("FAIL uf_count: beats=%0d rd_count=%0d required 4/4", mon_beats, rd_count);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bit ok;
        flush();
        mon_len = 8;
        s_if.ready = 1'b1;
        tick();
        do_start(8);
        for (int i = 0; i < 9; i++) begin
            push(8'h80 + 8'(i));
            tick();
        end
        wait_done(30, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_done: got no done required done within 30 cycles"); end
        checks++;
        if (mon_beats != 8) begin errors++; $display("FAIL b2b_beats: got %0d required 8", mon_beats); end
        checks++;
        if (fifo_q.size() != 1) begin
            errors++;
            $display("FAIL b2b_fifo_left: got %0d bytes required 1", fifo_q.size());
        end else if (fifo_q[0] !== 8'h88) begin
            errors++;
            $display("FAIL b2b_fifo_left: got 0x%02h required 0x88", fifo_q[0]);
        end
        checks++;
        if (exp_q.size() != 1) begin errors++; $display("FAIL b2b_exp_left: got %0d required 1", exp_q.size()); end
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        flush();
        for (int i = 0; i < 8; i++) push(8'h61 + 8'(i));
        mon_len = 6;
        s_if.ready = 1'b1;
        tick();
        do_start(6);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mon_beats >= 2) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok || mon_beats != 2) begin
            errors++;
            $display("FAIL rst_mid_reach: got %0d beats required 2 within 20 cycles", mon_beats);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, fifo_rd_en, s_if.valid, s_if.last} !== 5'b0) begin
            errors++;
            $display("FAIL rst_mid_ctrl: busy/done/rd_en/valid/last=%b required 00000",
                     {busy, done, fifo_rd_en, s_if.valid, s_if.last});
        end
        checks++;
        if (s_if.data !== 8'h00 || rd_count !== 8'd0) begin
            errors++;
            $display("FAIL rst_mid_data: data=0x%02h rd_count=%0d required 0x00/0", s_if.data, rd_count);
        end
        tick();
        rst_n = 1'b1;
        tick();
        exp_q     = fifo_q;
        mon_beats = 0;
        mon_len   = 2;
        do_start(2);
        wait_done(20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_mid_done: got no done required done within 20 cycles"); end
        checks++;
        if (mon_beats != 2) begin errors++; $display("FAIL rst_mid_beats: got %0d required 2", mon_beats); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_backpressure();
        test_underflow();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
